// File: rtl/cache_async_pkg.sv
// Shared constants for the async cache request path and its clocked consumers.
// Provides default widths/depths and the occupancy-counter width helper.
package cache_async_pkg;

    localparam int unsigned DATA_WIDTH_REQ  = 5;
    localparam int unsigned DEPTH_DEF       = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Occupancy needs DEPTH+1 distinct values so full and empty never alias.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cache_sync_nff.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Chain clears to 0 under synchronous reset.
module cache_sync_nff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cache_merge_sync_fifo.sv
// Clocked consumer of the two-phase drive/free token stream from the async merge.
// Tokens are synchronised, stored in a small FIFO and offered as valid/ready.
module cache_merge_sync_fifo
    import cache_async_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_REQ,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_drive,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic                          o_free,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    input  logic                          i_ready,
    output logic [count_width(DEPTH)-1:0] o_count,
    output logic                          o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    logic                  sync_out;
    logic                  phase_q;
    logic                  pending;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  tok_c;
    logic                  pop_c;
    logic                  push_c;
    logic [PTR_W-1:0]      rd_nxt_c;
    logic [CNT_W-1:0]      count_nopush_c;
    logic [CNT_W-1:0]      count_nxt_c;

    cache_sync_nff #(
        .STAGES (SYNC_STAGES)
    ) u_drive_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_drive),
        .q   (sync_out)
    );

    // Token detect, accept decision and next occupancy.
    always_comb begin
        tok_c          = sync_out ^ phase_q;
        pop_c          = o_valid & i_ready;
        push_c         = tok_c & (~o_full | pop_c);
        rd_nxt_c       = rd_ptr;
        if (pop_c) begin
            rd_nxt_c = rd_ptr + PTR_W'(1);
        end
        count_nopush_c = o_count - CNT_W'(pop_c);
        count_nxt_c    = count_nopush_c + CNT_W'(push_c);
    end

    // Head register shows the post-pop state; a word pushed this cycle appears next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            o_free  <= 1'b0;
            pending <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_count <= '0;
            o_full  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                phase_q <= sync_out;
                o_free  <= ~o_free;
            end
            pending <= tok_c & ~push_c;
            rd_ptr  <= rd_nxt_c;
            o_count <= count_nxt_c;
            o_full  <= (count_nxt_c == CNT_W'(DEPTH));
            o_valid <= (count_nopush_c != '0);
            o_data  <= mem[rd_nxt_c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // A held token cannot vanish: upstream may not move drive until free toggles.
    pending_holds_token: assert property (@(posedge clk) disable iff (rst) pending |-> tok_c);

endmodule

// File: tb/tb_cache_merge_sync_fifo.sv
// Self-checking bench for cache_merge_sync_fifo: directed token scenarios plus
// a randomised producer/consumer run checked against an in-order queue model.
module tb_cache_merge_sync_fifo;

    logic       clk;
    logic       rst;
    logic       i_drive;
    logic [4:0] i_data;
    logic       o_free;
    logic       o_valid;
    logic [4:0] o_data;
    logic       i_ready;
    logic [2:0] o_count;
    logic       o_full;

    int vectors;
    int miscompares;

    cache_merge_sync_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .i_drive (i_drive),
        .i_data  (i_data),
        .o_free  (o_free),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_count (o_count),
        .o_full  (o_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [4:0] d);
        i_data  = d;
        i_drive = ~i_drive;
    endtask

    task automatic wait_free(input logic prev, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk); #1;
            if (o_free !== prev) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_drive = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            i_drive = ~i_drive;
        end
        i_drive = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({o_valid, o_free, o_full, o_count, o_data} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_in_rst: outputs=%b required all 0", {o_valid, o_free, o_full, o_count, o_data});
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({o_valid, o_free, o_full, o_count, o_data} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_after_release c=%0d: outputs=%b required all 0", c, {o_valid, o_free, o_full, o_count, o_data});
            end
        end
    endtask

    task automatic test_single_token();
        logic free0;
        i_ready = 1'b1;
        free0   = o_free;
        send(5'h15);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            case (c)
                1, 2: if (o_free !== free0) begin
                    miscompares++;
                    $display("FAIL single_free_early c=%0d: o_free=%b required %b", c, o_free, free0);
                end
                3: if (o_free !== ~free0 || o_valid !== 1'b0 || o_count !== 3'd1) begin
                    miscompares++;
                    $display("FAIL single_write c=3: o_free=%b o_valid=%b o_count=%0d required %b 0 1", o_free, o_valid, o_count, ~free0);
                end
                4: if (o_valid !== 1'b1 || o_data !== 5'h15 || o_count !== 3'd1) begin
                    miscompares++;
                    $display("FAIL single_head c=4: o_valid=%b o_data=%h o_count=%0d required 1 15 1", o_valid, o_data, o_count);
                end
                default: if (o_valid !== 1'b0 || o_count !== 3'd0) begin
                    miscompares++;
                    $display("FAIL single_drain c=5: o_valid=%b o_count=%0d required 0 0", o_valid, o_count);
                end
            endcase
        end
    endtask

    task automatic test_fill();
        bit   ok;
        logic prev;
        do_reset();
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            prev = o_free;
            send(5'(k));
            wait_free(prev, 12, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL fill_ack k=%0d: o_free=%b required toggle", k, o_free);
            end
        end
        vectors++;
        if (o_full !== 1'b1 || o_count !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_full: o_full=%b o_count=%0d required 1 4", o_full, o_count);
        end
        prev = o_free;
        send(5'h05);
        repeat (8) @(posedge clk);
        #1;
        vectors++;
        if (o_free !== prev || o_count !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_withheld: o_free=%b o_count=%0d required %b 4", o_free, o_count, prev);
        end
    endtask

    task automatic test_full_push_pop();
        logic       prev;
        logic [4:0] expq [4];
        int         idx;
        expq = '{5'h02, 5'h03, 5'h04, 5'h05};
        prev = o_free;
        @(negedge clk);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 5'h01) begin
            miscompares++;
            $display("FAIL fullpp_head: o_valid=%b o_data=%h required 1 01", o_valid, o_data);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        vectors++;
        if (o_free !== ~prev || o_count !== 3'd4 || o_full !== 1'b1 || o_valid !== 1'b1 || o_data !== 5'h02) begin
            miscompares++;
            $display("FAIL fullpp_step: o_free=%b o_count=%0d o_full=%b o_valid=%b o_data=%h required %b 4 1 1 02",
                     o_free, o_count, o_full, o_valid, o_data, ~prev);
        end
        i_ready = 1'b1;
        idx     = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            if (o_valid) begin
                vectors++;
                if (o_data !== expq[idx]) begin
                    miscompares++;
                    $display("FAIL drain_order idx=%0d: o_data=%h required %h", idx, o_data, expq[idx]);
                end
                idx++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (idx != 4 || o_count !== 3'd0 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_done: popped=%0d o_count=%0d o_valid=%b required 4 0 0", idx, o_count, o_valid);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit   ok;
        logic prev;
        int   pops;
        do_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            prev = o_free;
            send(5'h11 + 5'(k));
            wait_free(prev, 12, ok);
        end
        vectors++;
        if (o_count !== 3'd2) begin
            miscompares++;
            $display("FAIL mid_pre: o_count=%0d required 2", o_count);
        end
        send(5'h13);
        @(posedge clk); #1;
        rst     = 1'b1;
        i_drive = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (o_count !== 3'd0 || o_free !== 1'b0 || o_valid !== 1'b0 || o_full !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: o_count=%0d o_free=%b o_valid=%b o_full=%b required 0 0 0 0", o_count, o_free, o_valid, o_full);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        prev = o_free;
        send(5'h0A);
        pops = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_valid) begin
                pops++;
                vectors++;
                if (o_data !== 5'h0A) begin
                    miscompares++;
                    $display("FAIL mid_restart_data: o_data=%h required 0a", o_data);
                end
            end
        end
        vectors++;
        if (pops != 1 || o_free !== ~prev) begin
            miscompares++;
            $display("FAIL mid_restart_count: pops=%0d o_free=%b required 1 %b", pops, o_free, ~prev);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] model_q [$];
        int         got;
        int         toggles;
        bit         prod_done;
        logic       last_free;
        do_reset();
        @(posedge clk); #1;
        got       = 0;
        toggles   = 0;
        prod_done = 1'b0;
        last_free = o_free;
        fork
            begin : producer
                bit         ok;
                logic       prev;
                logic [4:0] d;
                for (int i = 0; i < 500; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    d = 5'($urandom);
                    model_q.push_back(d);
                    prev = o_free;
                    send(d);
                    wait_free(prev, 200, ok);
                    if (!ok) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rand_ack_timeout token=%0d: o_free=%b required toggle", i, o_free);
                        break;
                    end
                end
                prod_done = 1'b1;
            end
            begin : consumer
                for (int c = 0; c < 30000 && got < 500; c++) begin
                    @(posedge clk); #2;
                    i_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (o_free !== last_free) begin
                        toggles++;
                        last_free = o_free;
                    end
                    if (o_valid && i_ready) begin
                        vectors++;
                        if (model_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL rand_spurious: o_data=%h required no valid", o_data);
                        end else begin
                            if (o_data !== model_q[0]) begin
                                miscompares++;
                                $display("FAIL rand_data n=%0d: o_data=%h required %h", got, o_data, model_q[0]);
                            end
                            void'(model_q.pop_front());
                        end
                        got++;
                    end
                    if (prod_done && got >= 500) break;
                end
            end
        join
        i_ready = 1'b0;
        vectors++;
        if (got != 500 || toggles != 500 || model_q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_totals: received=%0d free_toggles=%0d left=%0d required 500 500 0", got, toggles, model_q.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        i_drive     = 1'b0;
        i_data      = '0;
        i_ready     = 1'b0;
        test_reset();
        test_single_token();
        test_fill();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
